display_digit_scanner: RTL and testbench



---
 rtl/display_pkg.sv | 18 +
 rtl/bin_to_bcd.sv | 67 ++++++
 rtl/display_digit_scanner.sv | 125 ++++++++++++
 tb/tb_display_digit_scanner.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants and FSM state type for the digit scanner and its BCD engine.
package display_pkg;

    localparam logic signed [4:0] DIG_BLANK = 5'sd15;
    localparam logic signed [4:0] DIG_DASH  = -5'sd1;
    localparam int unsigned       MAX_VAL   = 9999;

    localparam int BIN_W = 14;
    localparam int BCD_W = 16;
    localparam int ITERS = 14;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } state_t;

endpackage

// File: rtl/bin_to_bcd.sv
// Sequential double-dabble converter: one adjust-and-shift iteration per clock.
// done is high during the final iteration; bcd_out is valid after that edge.
module bin_to_bcd
    import display_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd_out
);

    localparam int SH_W = BCD_W + BIN_W;

    logic [SH_W-1:0] sh_q, sh_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            busy_q, busy_d;

    function automatic logic [SH_W-1:0] add3(input logic [SH_W-1:0] s);
        logic [SH_W-1:0] r;
        r = s;
        for (int k = 0; k < 4; k++) begin
            if (r[BIN_W+4*k +: 4] >= 4'd5) begin
                r[BIN_W+4*k +: 4] = r[BIN_W+4*k +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    always_comb begin
        logic [SH_W-1:0] adj;
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        adj    = add3(sh_q);
        if (start && !busy_q) begin
            sh_d   = {{BCD_W{1'b0}}, bin_in};
            cnt_d  = 4'd0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            sh_d  = {adj[SH_W-2:0], 1'b0};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'(ITERS - 1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q   <= '0;
            cnt_q  <= 4'd0;
            busy_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign done    = busy_q && (cnt_q == 4'(ITERS - 1));
    assign bcd_out = sh_q[SH_W-1:BIN_W];

endmodule

// File: rtl/display_digit_scanner.sv
// Accepts a 14-bit value, converts it to BCD and scans four digit codes onto a
// common-anode display. Define LEADING_ZERO_BLANK_EN to blank leading zeros.
module display_digit_scanner
    import display_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [13:0]       val_in,
    input  logic              val_valid,
    output logic              val_ready,
    output logic signed [4:0] dig_code,
    output logic [3:0]        dig_an
);

    localparam int PRE_W = $clog2(SCAN_DIV);

    // val_valid/val_ready: a value transfers on any clock edge where both are
    // high; upstream holds val_valid and val_in stable until that edge.
    state_t            state_q, state_d;
    logic              ready_q, ready_d;
    logic              ovf_q, ovf_d;
    logic signed [4:0] disp_q [4];
    logic signed [4:0] disp_d [4];
    logic signed [4:0] new_dig [4];
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [1:0]        idx_q, idx_d;
    logic signed [4:0] code_q, code_d;
    logic [3:0]        an_q, an_d;

    logic              accept;
    logic              bcd_busy, bcd_done;
    logic [BCD_W-1:0]  bcd;

    assign accept = val_valid && ready_q;

    bin_to_bcd u_bin_to_bcd (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && !bcd_busy),
        .bin_in  (val_in),
        .busy    (bcd_busy),
        .done    (bcd_done),
        .bcd_out (bcd)
    );

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            new_dig[i] = {1'b0, bcd[4*i +: 4]};
        end
`ifdef LEADING_ZERO_BLANK_EN
        if (bcd[15:12] == 4'd0) new_dig[3] = DIG_BLANK;
        if (bcd[15:8]  == 8'd0) new_dig[2] = DIG_BLANK;
        if (bcd[15:4]  == 12'd0) new_dig[1] = DIG_BLANK;
`endif
        if (ovf_q) begin
            for (int i = 0; i < 4; i++) begin
                new_dig[i] = DIG_DASH;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ovf_d   = ovf_q;
        disp_d  = disp_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CONV;
                    ovf_d   = ({18'd0, val_in} > MAX_VAL);
                end
            end
            CONV: begin
                if (bcd_done) state_d = COMMIT;
            end
            COMMIT: begin
                disp_d  = new_dig;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);

        pre_d = pre_q + PRE_W'(1);
        idx_d = idx_q;
        if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
            pre_d = '0;
            idx_d = idx_q + 2'd1;
        end
        // Code and anode come from next-cycle index and data so they never disagree.
        code_d = disp_d[idx_d];
        an_d   = ~(4'b0001 << idx_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                disp_q[i] <= DIG_BLANK;
            end
            pre_q  <= '0;
            idx_q  <= 2'd0;
            code_q <= DIG_BLANK;
            an_q   <= 4'b1110;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            ovf_q   <= ovf_d;
            disp_q  <= disp_d;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            code_q  <= code_d;
            an_q    <= an_d;
        end
    end

    assign val_ready = ready_q;
    assign dig_code  = code_q;
    assign dig_an    = an_q;

endmodule

// File: tb/tb_display_digit_scanner.sv
// Directed and randomized bench for display_digit_scanner with a decimal reference model.
module tb_display_digit_scanner;

    localparam int SD = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [13:0]       val_in;
    logic              val_valid;
    logic              val_ready;
    logic signed [4:0] dig_code;
    logic [3:0]        dig_an;

    int checks   = 0;
    int failures = 0;
    int cyc;
    logic [19:0] exp_q[$];

    display_digit_scanner #(.SCAN_DIV(SD)) dut (
        .clk       (clk),
        .rst       (rst),
        .val_in    (val_in),
        .val_valid (val_valid),
        .val_ready (val_ready),
        .dig_code  (dig_code),
        .dig_an    (dig_an)
    );

    // clock / reset-relative cycle count
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    localparam logic [19:0] ALL_BLANK = {4{5'd15}};

    // Four digit codes (5-bit each, digit 0 in the low bits) for a value.
    function automatic logic [19:0] model(input int v);
        logic [19:0] r;
        int p;
        p = 1;
        for (int i = 0; i < 4; i++) begin
            if (v > 9999) begin
                r[5*i +: 5] = 5'b11111;
            end else begin
                r[5*i +: 5] = 5'((v / p) % 10);
`ifdef LEADING_ZERO_BLANK_EN
                if (i > 0 && v < p) r[5*i +: 5] = 5'd15;
`endif
            end
            p = p * 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge. Samples 16 cycles, covering every slot for SD=4.
    task automatic check_display(input string tag);
        logic [19:0] e;
        logic [3:0]  ean;
        int          k;
        chk({tag, "_sb_nonempty"}, (exp_q.size() > 0), 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : ALL_BLANK;
        for (int n = 0; n < 16; n++) begin
            k   = (cyc / SD) % 4;
            ean = ~(4'b0001 << k);
            chk({tag, "_an"}, {28'd0, dig_an}, {28'd0, ean});
            chk({tag, "_code"}, {27'd0, dig_code}, {27'd0, e[5*k +: 5]});
            @(negedge clk);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (val_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready_timeout"}, (n < 100), 1);
    endtask

    // driver: called at a negedge; returns cycles val_ready stayed low after accept
    task automatic send(input int v, output int lowcnt);
        wait_ready("send");
        val_in    = 14'(v);
        val_valid = 1'b1;
        @(negedge clk);
        val_valid = 1'b0;
        exp_q.push_back(model(v));
        lowcnt = 0;
        while (val_ready !== 1'b1 && lowcnt < 40) begin
            lowcnt++;
            @(negedge clk);
        end
    endtask

    task automatic send_check(input string tag, input int v);
        int l;
        send(v, l);
        chk({tag, "_latency"}, l, 15);
        check_display(tag);
    endtask

    initial begin
        int l;
        int k;
        logic [19:0] e;

        rst       = 1'b1;
        val_valid = 1'b0;
        val_in    = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, val_ready}, 0);
        chk("rst_an", {28'd0, dig_an}, 32'hE);
        chk("rst_code", {27'd0, dig_code}, 15);
        rst = 1'b0;
        chk("rel_ready_low", {31'd0, val_ready}, 0);
        @(negedge clk);
        chk("rel_ready_rise", {31'd0, val_ready}, 1);
        exp_q.push_back(ALL_BLANK);
        check_display("reset_blank");

        send(1234, l);
        chk("lat_1234", l, 15);
        check_display("d1234");
        send_check("ovf10000", 10000);
        send_check("ovf16383", 16383);
        send_check("d9999", 9999);
        send_check("d7", 7);
        send_check("d0", 0);
        send_check("d42", 42);

        // hold val_valid through conversion, change val_in mid-way
        wait_ready("hold");
        val_in    = 14'd5555;
        val_valid = 1'b1;
        @(negedge clk);
        chk("hold_t0_ready", {31'd0, val_ready}, 0);
        repeat (4) @(negedge clk);
        chk("hold_t4_ready", {31'd0, val_ready}, 0);
        val_in = 14'd1111;
        repeat (10) @(negedge clk);
        chk("hold_t14_ready", {31'd0, val_ready}, 0);
        @(negedge clk);
        chk("hold_t15_ready", {31'd0, val_ready}, 1);
        e = model(5555);
        k = (cyc / SD) % 4;
        chk("hold_t15_code", {27'd0, dig_code}, {27'd0, e[5*k +: 5]});
        @(negedge clk);
        chk("hold_t16_accept", {31'd0, val_ready}, 0);
        val_valid = 1'b0;
        exp_q.push_back(model(1111));
        wait_ready("hold2");
        check_display("hold_1111");

        // reset mid-conversion over a prior display of 321
        send_check("d321", 321);
        wait_ready("abort");
        val_in    = 14'd8888;
        val_valid = 1'b1;
        @(negedge clk);
        val_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_code", {27'd0, dig_code}, 15);
        chk("abort_an", {28'd0, dig_an}, 32'hE);
        chk("abort_ready", {31'd0, val_ready}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(ALL_BLANK);
        check_display("abort_blank");
        send_check("after_abort_42", 42);

        // randomized values across the full input range
        for (int r = 0; r < 8; r++) begin
            send_check("rand", int'($urandom_range(0, 16383)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
